// File: rtl/pass_playback.sv
// pass_playback: replays a stored binary passcode as decimal digits, most
// significant first, over a valid/ready stream. A sequential double-dabble
// engine converts the code to BCD, then SIZE digits are emitted.
//
// Optional feature macro: DIGIT_RANGE_CHECK_EN
//   defined  : after conversion, any digit equal to 0 or above 6 aborts the
//              playback with err (only keypad keys 1..6 are legal).
//   undefined: every value 0..10**SIZE-1 replays, zeros included.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, pass        playback request and the binary code (sampled in IDLE)
//   busy               operation in flight
//   digit, digit_idx   current digit value and position (0 = most significant)
//   digit_valid/ready  stream handshake; last marks digit_idx == SIZE-1
//   done, err          one-cycle completion pulse; err held until next start
module pass_playback #(
    parameter int unsigned SIZE  = 6,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned BIN_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pass,
    output logic             busy,
    output logic [WIDTH-1:0] digit,
    output logic [2:0]       digit_idx,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             last,
    output logic             done,
    output logic             err
);

    localparam int unsigned BCD_W = SIZE * WIDTH;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned IDX_W = 3;
    localparam logic [31:0] PASS_LIMIT = 32'(10 ** SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_CHECK,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pass_q, pass_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   digit_q, digit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [IDX_W-1:0]   idx_nxt;

    // Digit at stream position idx (position 0 is the top nibble).
    function automatic logic [WIDTH-1:0] sel_digit(input logic [BCD_W-1:0] b,
                                                   input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < int'(SIZE); k++) begin
            if (IDX_W'(k) == idx) r = b[(int'(SIZE) - 1 - k) * int'(WIDTH) +: WIDTH];
        end
        return r;
    endfunction

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [WIDTH-1:0] nib;
        r = b;
        for (int k = 0; k < int'(SIZE); k++) begin
            nib = b[k * int'(WIDTH) +: WIDTH];
            if (nib >= WIDTH'(5)) r[k * int'(WIDTH) +: WIDTH] = nib + WIDTH'(3);
        end
        return r;
    endfunction

`ifdef DIGIT_RANGE_CHECK_EN
    // True when any digit falls outside the keypad key range 1..6.
    function automatic logic digit_out_of_range(input logic [BCD_W-1:0] b);
        logic             bad;
        logic [WIDTH-1:0] nib;
        bad = 1'b0;
        for (int k = 0; k < int'(SIZE); k++) begin
            nib = b[k * int'(WIDTH) +: WIDTH];
            if ((nib == WIDTH'(0)) || (nib > WIDTH'(6))) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    assign bcd_adj = bcd_adjust(bcd_q);
    assign idx_nxt = idx_q + IDX_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        digit_d = digit_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pass_d  = pass;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Full 32-bit compare: bits above BIN_W must also be covered.
                if (pass_q >= PASS_LIMIT) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    bin_d   = pass_q[BIN_W-1:0];
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_CONVERT;
                end
            end

            S_CONVERT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_CHECK;
            end

            S_CHECK: begin
                idx_d   = '0;
                digit_d = sel_digit(bcd_q, '0);
                last_d  = (IDX_W'(SIZE - 1) == '0);
                valid_d = 1'b1;
                state_d = S_EMIT;
`ifdef DIGIT_RANGE_CHECK_EN
                if (digit_out_of_range(bcd_q)) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end
`endif
            end

            S_EMIT: begin
                // Next digit is presented straight after a transfer, no bubble.
                if (digit_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_nxt;
                        digit_d = sel_digit(bcd_q, idx_nxt);
                        last_d  = (idx_nxt == IDX_W'(SIZE - 1));
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            digit_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            digit_q <= digit_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy        = busy_q;
    assign digit       = digit_q;
    assign digit_idx   = idx_q;
    assign digit_valid = valid_q;
    assign last        = last_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pass_playback.sv
// tb_pass_playback: directed bench for pass_playback. Expected digits are
// computed from the passcode by decimal division and queued when a playback
// is started; they are popped and compared as the DUT transfers them.
module tb_pass_playback;

    localparam int unsigned SIZE  = 6;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned BIN_W = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      pass;
    logic             busy;
    logic [WIDTH-1:0] digit;
    logic [2:0]       digit_idx;
    logic             digit_valid;
    logic             digit_ready;
    logic             last;
    logic             done;
    logic             err;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] idx;
        logic       lst;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_err;

    pass_playback #(.SIZE(SIZE), .WIDTH(WIDTH), .BIN_W(BIN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pass        (pass),
        .busy        (busy),
        .digit       (digit),
        .digit_idx   (digit_idx),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .last        (last),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a playback of p and follow it to completion. The consumer stalls
    // stall_n cycles on digit position stall_idx; start is re-pulsed at
    // cycle restart_cyc (-1: never) and must be ignored.
    task automatic play(input logic [31:0] p, input int stall_idx, input int stall_n,
                        input int restart_cyc);
        logic exp_err;
        int   exp_first, exp_done, first_valid, done_cyc, done_cnt, cyc, stalled;
        int unsigned div, dv;
        rec_t r;

        exp_err = (p >= 32'd1000000);
        sb.delete();
        if (!exp_err) begin
            div = 100000;
            for (int k = 0; k < int'(SIZE); k++) begin
                dv = (p / div) % 10;
`ifdef DIGIT_RANGE_CHECK_EN
                if (dv == 0 || dv > 6) exp_err = 1'b1;
`endif
                r.d   = 4'(dv);
                r.idx = 3'(k);
                r.lst = (k == int'(SIZE) - 1);
                sb.push_back(r);
                div = div / 10;
            end
            if (exp_err) sb.delete();
        end
        if (p >= 32'd1000000) begin
            exp_first = -1;
            exp_done  = 2;
        end else if (exp_err) begin
            exp_first = -1;
            exp_done  = int'(BIN_W) + 3;
        end else begin
            exp_first = int'(BIN_W) + 3;
            exp_done  = int'(BIN_W) + 3 + int'(SIZE) + stall_n;
        end

        check("err_held_before_start", 32'(err), 32'(prev_err));

        @(negedge clk);
        pass        = p;
        start       = 1'b1;
        digit_ready = 1'b1;
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        stalled     = 0;
        cyc         = 0;

        while (cyc < 200 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_cyc);
            pass  = ~p;
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared_on_start", 32'(err), 32'd0);
            end
            if (digit_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(digit_valid), 32'd0);
                end else begin
                    r = sb[0];
                    check("digit", 32'(digit), 32'(r.d));
                    check("digit_idx", 32'(digit_idx), 32'(r.idx));
                    check("last", 32'(last), 32'(r.lst));
                    if (int'(digit_idx) == stall_idx && stalled < stall_n) begin
                        digit_ready = 1'b0;
                        stalled++;
                    end else begin
                        digit_ready = 1'b1;
                    end
                    if (digit_ready) void'(sb.pop_front());
                end
            end else begin
                digit_ready = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_with_done", 32'(busy), 32'd0);
                check("err_with_done", 32'(err), 32'(exp_err));
            end
        end

        start       = 1'b0;
        digit_ready = 1'b1;
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("first_valid_cycle", 32'(first_valid), 32'(exp_first));
        check("digits_left", 32'(sb.size()), 32'd0);
        check("busy_idle_after", 32'(busy), 32'd0);
        check("err_held_after", 32'(err), 32'(exp_err));
        prev_err = exp_err;
        sb.delete();
    endtask

    initial begin
        int dn;

        rst         = 1'b1;
        start       = 1'b0;
        pass        = '0;
        digit_ready = 1'b0;
        prev_err    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        play(32'd121212, -1, 0, -1);
        play(32'd1000000, -1, 0, -1);
        play(32'd654321, 2, 5, -1);
        play(32'hFFFF_FFFF, -1, 0, -1);
        play(32'd1048576, -1, 0, -1);

        // Reset while emitting digit index 3.
        @(negedge clk);
        pass        = 32'd654321;
        start       = 1'b1;
        digit_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (digit_valid && digit_idx == 3'd3) break;
        end
        check("mid_reset_reached_idx3", 32'(digit_idx), 32'd3);
        rst         = 1'b1;
        digit_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(digit_valid), 32'd0);
        check("mid_rst_digit", 32'(digit), 32'd0);
        check("mid_rst_idx", 32'(digit_idx), 32'd0);
        check("mid_rst_last", 32'(last), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("mid_rst_no_done", 32'(dn), 32'd0);
        prev_err = 1'b0;
        digit_ready = 1'b1;

        play(32'd654321, -1, 0, -1);
        play(32'd12, -1, 0, -1);
        play(32'd123457, -1, 0, -1);
        play(32'd999999, 0, 2, -1);
        play(32'd121212, -1, 0, 5);
        play(32'd216543, -1, 0, int'(BIN_W) + 3 + int'(SIZE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
